// File: rtl/pc_predictor.sv
// rtl/pc_predictor.sv - fetch PC generator with direct-mapped BTB and 2-bit counters
//
// Purpose: produces the fetch PC each cycle, predicts taken branches/jumps
// from a direct-mapped branch target buffer, and redirects the PC (flushing
// IF/ID) when the execute stage reports a misprediction.
//
// Ports:
//   clock, reset             falling-edge clock, synchronous active-high reset
//   enable_pc                global enable; PC, BTB and perf counter hold when low
//   do_hazard, do_halt_pc    hold the PC
//   do_interrupt/interrupt_pc    jump to interrupt vector
//   do_it_load_pc/it_return_pc   return from interrupt
//   resolve_*                resolved control-flow info from execute
//   current_pc               fetch PC
//   pred_taken, pred_target  BTB prediction for current_pc
//   mispredict, do_flush_REG1    redirect in effect this cycle
//   perf_mispredict          saturating misprediction count
module pc_predictor #(
    parameter int                  PC_WIDTH    = 32,
    parameter int                  BTB_ENTRIES = 16,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable_pc,
    input  logic                do_hazard,
    input  logic                do_halt_pc,
    input  logic                do_interrupt,
    input  logic [PC_WIDTH-1:0] interrupt_pc,
    input  logic                do_it_load_pc,
    input  logic [PC_WIDTH-1:0] it_return_pc,
    input  logic                resolve_valid,
    input  logic [PC_WIDTH-1:0] resolve_pc,
    input  logic                resolve_taken,
    input  logic [PC_WIDTH-1:0] resolve_target,
    input  logic                resolve_pred_taken,
    input  logic [PC_WIDTH-1:0] resolve_pred_target,
    output logic [PC_WIDTH-1:0] current_pc,
    output logic                pred_taken,
    output logic [PC_WIDTH-1:0] pred_target,
    output logic                mispredict,
    output logic                do_flush_REG1,
    output logic [31:0]         perf_mispredict
);

    localparam int IDX   = $clog2(BTB_ENTRIES);
    localparam int TAG_W = PC_WIDTH - IDX - 2;

    logic [PC_WIDTH-1:0] pc_q;
    logic [PC_WIDTH-1:0] pc_d;
    logic [31:0]         perf_q;

    logic [BTB_ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]       tag_q    [BTB_ENTRIES];
    logic [PC_WIDTH-1:0]    target_q [BTB_ENTRIES];
    logic [1:0]             ctr_q    [BTB_ENTRIES];

    // Fetch-side lookup
    logic [IDX-1:0]   fetch_idx;
    logic [TAG_W-1:0] fetch_tag;
    logic             fetch_hit;

    assign fetch_idx = pc_q[IDX+1:2];
    assign fetch_tag = pc_q[PC_WIDTH-1:IDX+2];
    assign fetch_hit = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);

    assign pred_taken  = fetch_hit && ctr_q[fetch_idx][1];
    assign pred_target = fetch_hit ? target_q[fetch_idx] : '0;

    // Resolve-side lookup
    logic [IDX-1:0]   res_idx;
    logic [TAG_W-1:0] res_tag;
    logic             res_hit;
    logic             btb_we;
    logic [1:0]       ctr_inc;
    logic [1:0]       ctr_dec;

    assign res_idx = resolve_pc[IDX+1:2];
    assign res_tag = resolve_pc[PC_WIDTH-1:IDX+2];
    assign res_hit = valid_q[res_idx] && (tag_q[res_idx] == res_tag);
    assign btb_we  = resolve_valid && enable_pc;
    assign ctr_inc = (ctr_q[res_idx] == 2'b11) ? 2'b11 : ctr_q[res_idx] + 2'b01;
    assign ctr_dec = (ctr_q[res_idx] == 2'b00) ? 2'b00 : ctr_q[res_idx] - 2'b01;

    // A not-taken branch only mispredicts on direction; the predicted target
    // is meaningless unless the branch was actually taken.
    logic [PC_WIDTH-1:0] redirect_pc;

    assign mispredict = resolve_valid &&
                        ((resolve_taken != resolve_pred_taken) ||
                         (resolve_taken && (resolve_target != resolve_pred_target)));
    assign do_flush_REG1 = mispredict;
    assign redirect_pc   = resolve_taken ? resolve_target : resolve_pc + PC_WIDTH'(4);

    // Next fetch PC; first matching condition wins.
    always_comb begin
        pc_d = pc_q + PC_WIDTH'(4);
        if (!enable_pc) begin
            pc_d = pc_q;
        end else if (do_it_load_pc) begin
            pc_d = it_return_pc;
        end else if (do_interrupt) begin
            pc_d = interrupt_pc;
        end else if (mispredict) begin
            pc_d = redirect_pc;
        end else if (do_hazard || do_halt_pc) begin
            pc_d = pc_q;
        end else if (pred_taken) begin
            pc_d = pred_target;
        end
    end

    always_ff @(negedge clock) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            valid_q <= '0;
            perf_q  <= '0;
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                ctr_q[i] <= 2'b01;
            end
        end else begin
            pc_q <= pc_d;
            if (btb_we) begin
                if (resolve_taken) begin
                    // Hit: strengthen; miss: allocate as weak taken.
                    valid_q[res_idx] <= 1'b1;
                    tag_q[res_idx]   <= res_tag;
                    ctr_q[res_idx]   <= res_hit ? ctr_inc : 2'b10;
                end else if (res_hit) begin
                    ctr_q[res_idx] <= ctr_dec;
                end
            end
            if (mispredict && enable_pc && (perf_q != 32'hFFFF_FFFF)) begin
                perf_q <= perf_q + 32'd1;
            end
        end
    end

    // Targets are not cleared by reset; valid bits gate their use.
    always_ff @(negedge clock) begin
        if (!reset && btb_we && resolve_taken) begin
            target_q[res_idx] <= resolve_target;
        end
    end

    assign current_pc      = pc_q;
    assign perf_mispredict = perf_q;

endmodule

// File: tb/tb_pc_predictor.sv
// tb/tb_pc_predictor.sv - self-checking bench for pc_predictor
module tb_pc_predictor;

    localparam int          N   = 16;
    localparam int          IDX = 4;
    localparam logic [31:0] RST = 32'h0;

    logic        clock = 1'b0;
    logic        reset, enable_pc, do_hazard, do_halt_pc, do_interrupt, do_it_load_pc;
    logic [31:0] interrupt_pc, it_return_pc;
    logic        resolve_valid, resolve_taken, resolve_pred_taken;
    logic [31:0] resolve_pc, resolve_target, resolve_pred_target;
    logic [31:0] current_pc, pred_target, perf_mispredict;
    logic        pred_taken, mispredict, do_flush_REG1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    pc_predictor #(.PC_WIDTH(32), .BTB_ENTRIES(N), .RESET_PC(RST)) dut (
        .clock(clock), .reset(reset), .enable_pc(enable_pc),
        .do_hazard(do_hazard), .do_halt_pc(do_halt_pc),
        .do_interrupt(do_interrupt), .interrupt_pc(interrupt_pc),
        .do_it_load_pc(do_it_load_pc), .it_return_pc(it_return_pc),
        .resolve_valid(resolve_valid), .resolve_pc(resolve_pc),
        .resolve_taken(resolve_taken), .resolve_target(resolve_target),
        .resolve_pred_taken(resolve_pred_taken), .resolve_pred_target(resolve_pred_target),
        .current_pc(current_pc), .pred_taken(pred_taken), .pred_target(pred_target),
        .mispredict(mispredict), .do_flush_REG1(do_flush_REG1),
        .perf_mispredict(perf_mispredict)
    );

    // Reference model: table of entries keyed by (pc/4) mod N, tag = pc / (4N)
    bit                m_valid  [N];
    longint unsigned   m_tag    [N];
    logic [31:0]       m_target [N];
    int                m_ctr    [N];
    logic [31:0]       m_pc;
    longint unsigned   m_perf;

    function automatic int midx(logic [31:0] pc);
        return int'((pc / 4) % N);
    endfunction

    function automatic longint unsigned mtag(logic [31:0] pc);
        return longint'(pc) / (4 * N);
    endfunction

    function automatic bit mhit(logic [31:0] pc);
        return m_valid[midx(pc)] && (m_tag[midx(pc)] == mtag(pc));
    endfunction

    function automatic bit m_pt(logic [31:0] pc);
        return mhit(pc) && (m_ctr[midx(pc)] >= 2);
    endfunction

    function automatic logic [31:0] m_ptgt(logic [31:0] pc);
        return mhit(pc) ? m_target[midx(pc)] : 32'h0;
    endfunction

    function automatic bit m_mp();
        if (!resolve_valid) return 1'b0;
        if (resolve_taken != resolve_pred_taken) return 1'b1;
        return resolve_taken && (resolve_target != resolve_pred_target);
    endfunction

    // Advance the model using the inputs currently applied, then clock the DUT.
    task automatic step();
        logic [31:0] nxt;
        bit          mp;
        int          i;
        mp = m_mp();
        if (reset) begin
            m_pc   = RST;
            m_perf = 0;
            for (int k = 0; k < N; k++) begin
                m_valid[k] = 1'b0;
                m_ctr[k]   = 1;
            end
        end else if (enable_pc) begin
            if (do_it_load_pc)               nxt = it_return_pc;
            else if (do_interrupt)           nxt = interrupt_pc;
            else if (mp)                     nxt = resolve_taken ? resolve_target : resolve_pc + 32'd4;
            else if (do_hazard || do_halt_pc) nxt = m_pc;
            else if (m_pt(m_pc))             nxt = m_ptgt(m_pc);
            else                             nxt = m_pc + 32'd4;
            if (resolve_valid) begin
                i = midx(resolve_pc);
                if (resolve_taken) begin
                    m_ctr[i]    = mhit(resolve_pc) ? ((m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1) : 2;
                    m_valid[i]  = 1'b1;
                    m_tag[i]    = mtag(resolve_pc);
                    m_target[i] = resolve_target;
                end else if (mhit(resolve_pc)) begin
                    m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
                end
            end
            if (mp && m_perf < 64'hFFFF_FFFF) m_perf++;
            m_pc = nxt;
        end
        @(negedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        do_hazard = 0; do_halt_pc = 0; do_interrupt = 0; do_it_load_pc = 0;
        resolve_valid = 0; resolve_taken = 0; resolve_pred_taken = 0;
        resolve_pc = 0; resolve_target = 0; resolve_pred_target = 0;
    endtask

    task automatic set_resolve(logic [31:0] pc, logic tk, logic [31:0] tgt,
                               logic ptk, logic [31:0] ptgt);
        resolve_valid = 1; resolve_pc = pc; resolve_taken = tk; resolve_target = tgt;
        resolve_pred_taken = ptk; resolve_pred_target = ptgt;
    endtask

    task automatic jump_to(logic [31:0] pc);
        do_interrupt = 1; interrupt_pc = pc;
        step();
        do_interrupt = 0;
    endtask

    task automatic test_reset();
        reset = 1; enable_pc = 1; clear_inputs(); interrupt_pc = 0; it_return_pc = 0;
        step();
        reset = 0;
        n_checks++; if (perf_mispredict !== 32'h0) begin n_fail++; $display("FAIL reset_perf: got %h expected %h", perf_mispredict, 32'h0); end
        for (int k = 0; k < 4; k++) begin
            n_checks++; if (current_pc !== 32'(4 * k)) begin n_fail++; $display("FAIL seq_pc%0d: got %h expected %h", k, current_pc, 32'(4 * k)); end
            n_checks++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL seq_pred%0d: got %b expected 0", k, pred_taken); end
            n_checks++; if (pred_target !== 32'h0) begin n_fail++; $display("FAIL seq_ptgt%0d: got %h expected 0", k, pred_target); end
            step();
        end
    endtask

    task automatic test_mispredict_alloc();
        set_resolve(32'h10, 1, 32'h40, 0, 32'h0);
        #1;
        n_checks++; if (mispredict !== 1'b1) begin n_fail++; $display("FAIL alloc_mp: got %b expected 1", mispredict); end
        n_checks++; if (do_flush_REG1 !== 1'b1) begin n_fail++; $display("FAIL alloc_flush: got %b expected 1", do_flush_REG1); end
        step(); clear_inputs();
        n_checks++; if (current_pc !== 32'h40) begin n_fail++; $display("FAIL alloc_pc: got %h expected %h", current_pc, 32'h40); end
        n_checks++; if (perf_mispredict !== 32'd1) begin n_fail++; $display("FAIL alloc_perf: got %0d expected 1", perf_mispredict); end
        jump_to(32'h10); #1;
        n_checks++; if (pred_taken !== 1'b1) begin n_fail++; $display("FAIL alloc_hit: got %b expected 1", pred_taken); end
        n_checks++; if (pred_target !== 32'h40) begin n_fail++; $display("FAIL alloc_tgt: got %h expected %h", pred_target, 32'h40); end
        step();
        n_checks++; if (current_pc !== 32'h40) begin n_fail++; $display("FAIL alloc_follow: got %h expected %h", current_pc, 32'h40); end
    endtask

    task automatic test_hysteresis();
        set_resolve(32'h10, 1, 32'h40, 1, 32'h40); #1;
        n_checks++; if (mispredict !== 1'b0) begin n_fail++; $display("FAIL hyst_nomp: got %b expected 0", mispredict); end
        step(); clear_inputs();
        set_resolve(32'h10, 0, 32'h0, 1, 32'h40); #1;
        n_checks++; if (mispredict !== 1'b1) begin n_fail++; $display("FAIL hyst_mp1: got %b expected 1", mispredict); end
        step(); clear_inputs();
        n_checks++; if (current_pc !== 32'h14) begin n_fail++; $display("FAIL hyst_redirect1: got %h expected %h", current_pc, 32'h14); end
        jump_to(32'h10); #1;
        n_checks++; if (pred_taken !== 1'b1) begin n_fail++; $display("FAIL hyst_weak_taken: got %b expected 1", pred_taken); end
        set_resolve(32'h10, 0, 32'h0, 1, 32'h40);
        step(); clear_inputs();
        n_checks++; if (current_pc !== 32'h14) begin n_fail++; $display("FAIL hyst_redirect2: got %h expected %h", current_pc, 32'h14); end
        jump_to(32'h10); #1;
        n_checks++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL hyst_weak_nt: got %b expected 0", pred_taken); end
        step();
        n_checks++; if (current_pc !== 32'h14) begin n_fail++; $display("FAIL hyst_fallthru: got %h expected %h", current_pc, 32'h14); end
    endtask

    task automatic test_aliasing();
        set_resolve(32'h10, 1, 32'h40, 0, 32'h0);
        step(); clear_inputs();
        jump_to(32'h10); #1;
        n_checks++; if (pred_taken !== 1'b1) begin n_fail++; $display("FAIL alias_own: got %b expected 1", pred_taken); end
        jump_to(32'h50); #1;
        n_checks++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL alias_pt: got %b expected 0", pred_taken); end
        n_checks++; if (pred_target !== 32'h0) begin n_fail++; $display("FAIL alias_tgt: got %h expected 0", pred_target); end
        step();
        n_checks++; if (current_pc !== 32'h54) begin n_fail++; $display("FAIL alias_pc: got %h expected %h", current_pc, 32'h54); end
    endtask

    task automatic test_priority();
        do_interrupt = 1; interrupt_pc = 32'h200;
        set_resolve(32'h80, 1, 32'h300, 0, 32'h0); #1;
        n_checks++; if (mispredict !== 1'b1) begin n_fail++; $display("FAIL prio_mp: got %b expected 1", mispredict); end
        step(); clear_inputs();
        n_checks++; if (current_pc !== 32'h200) begin n_fail++; $display("FAIL prio_int: got %h expected %h", current_pc, 32'h200); end
        jump_to(32'h80); #1;
        n_checks++; if (pred_taken !== 1'b1) begin n_fail++; $display("FAIL prio_btb_pt: got %b expected 1", pred_taken); end
        n_checks++; if (pred_target !== 32'h300) begin n_fail++; $display("FAIL prio_btb_tgt: got %h expected %h", pred_target, 32'h300); end
        do_hazard = 1;
        set_resolve(32'h90, 0, 32'h0, 1, 32'h300);
        step(); clear_inputs();
        n_checks++; if (current_pc !== 32'h94) begin n_fail++; $display("FAIL prio_hazard_mp: got %h expected %h", current_pc, 32'h94); end
        do_halt_pc = 1;
        step(); step();
        do_halt_pc = 0;
        n_checks++; if (current_pc !== 32'h94) begin n_fail++; $display("FAIL prio_halt: got %h expected %h", current_pc, 32'h94); end
    endtask

    task automatic test_wrap();
        jump_to(32'hFFFF_FFFC); #1;
        n_checks++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL wrap_pt: got %b expected 0", pred_taken); end
        step();
        n_checks++; if (current_pc !== 32'h0) begin n_fail++; $display("FAIL wrap_pc: got %h expected 0", current_pc); end
    endtask

    task automatic test_enable();
        enable_pc = 0;
        set_resolve(32'hA0, 1, 32'h500, 0, 32'h0); #1;
        n_checks++; if (mispredict !== 1'b1) begin n_fail++; $display("FAIL en_mp_comb: got %b expected 1", mispredict); end
        step(); clear_inputs();
        n_checks++; if (current_pc !== 32'h0) begin n_fail++; $display("FAIL en_pc_hold: got %h expected 0", current_pc); end
        n_checks++; if (perf_mispredict !== 32'd6) begin n_fail++; $display("FAIL en_perf_hold: got %0d expected 6", perf_mispredict); end
        enable_pc = 1;
        jump_to(32'hA0); #1;
        n_checks++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL en_btb_hold: got %b expected 0", pred_taken); end
    endtask

    task automatic test_mid_reset();
        reset = 1;
        set_resolve(32'h10, 1, 32'h40, 0, 32'h0);
        step(); clear_inputs(); reset = 0;
        n_checks++; if (current_pc !== RST) begin n_fail++; $display("FAIL mreset_pc: got %h expected %h", current_pc, RST); end
        n_checks++; if (perf_mispredict !== 32'h0) begin n_fail++; $display("FAIL mreset_perf: got %0d expected 0", perf_mispredict); end
        jump_to(32'h10); #1;
        n_checks++; if (pred_taken !== 1'b0 || pred_target !== 32'h0) begin n_fail++; $display("FAIL mreset_miss10: got %b/%h expected 0/0", pred_taken, pred_target); end
        jump_to(32'h80); #1;
        n_checks++; if (pred_taken !== 1'b0 || pred_target !== 32'h0) begin n_fail++; $display("FAIL mreset_miss80: got %b/%h expected 0/0", pred_taken, pred_target); end
    endtask

    task automatic test_random();
        logic [31:0] rpc;
        for (int c = 0; c < 400; c++) begin
            reset         = ($urandom_range(0, 99) == 0);
            enable_pc     = ($urandom_range(0, 15) != 0);
            do_hazard     = ($urandom_range(0, 7) == 0);
            do_halt_pc    = ($urandom_range(0, 7) == 0);
            do_interrupt  = ($urandom_range(0, 15) == 0);
            do_it_load_pc = ($urandom_range(0, 15) == 0);
            interrupt_pc  = 32'($urandom_range(0, 63)) << 2;
            it_return_pc  = 32'($urandom_range(0, 63)) << 2;
            rpc = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2);
            resolve_valid  = $urandom_range(0, 1);
            resolve_pc     = rpc;
            resolve_taken  = $urandom_range(0, 1);
            resolve_target = 32'($urandom_range(0, 63)) << 2;
            if ($urandom_range(0, 1) == 1) begin
                resolve_pred_taken  = m_pt(rpc);
                resolve_pred_target = m_ptgt(rpc);
            end else begin
                resolve_pred_taken  = $urandom_range(0, 1);
                resolve_pred_target = 32'($urandom_range(0, 63)) << 2;
            end
            #1;
            n_checks++; if (pred_taken !== m_pt(m_pc)) begin n_fail++; $display("FAIL rnd_pt c%0d: got %b expected %b", c, pred_taken, m_pt(m_pc)); end
            n_checks++; if (pred_target !== m_ptgt(m_pc)) begin n_fail++; $display("FAIL rnd_tgt c%0d: got %h expected %h", c, pred_target, m_ptgt(m_pc)); end
            n_checks++; if (mispredict !== m_mp() || do_flush_REG1 !== m_mp()) begin n_fail++; $display("FAIL rnd_mp c%0d: got %b/%b expected %b", c, mispredict, do_flush_REG1, m_mp()); end
            step();
            n_checks++; if (current_pc !== m_pc) begin n_fail++; $display("FAIL rnd_pc c%0d: got %h expected %h", c, current_pc, m_pc); end
            n_checks++; if (perf_mispredict !== m_perf[31:0]) begin n_fail++; $display("FAIL rnd_perf c%0d: got %0d expected %0d", c, perf_mispredict, m_perf[31:0]); end
        end
        reset = 0; enable_pc = 1; clear_inputs();
    endtask

    initial begin
        test_reset();
        test_mispredict_alloc();
        test_hysteresis();
        test_aliasing();
        test_priority();
        test_wrap();
        test_enable();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
